// File: rtl/decoder_pkg.sv
// Shared types for the registered code decoder / strobe generator.
// Latency: n/a (types only). Backpressure: n/a.
// Mode encoding matches the in_mode field on the request interface.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'b00,
        MODE_THERMO  = 2'b01,
        MODE_ITHERMO = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_core.sv
// Combinational code-to-word decoder: one-hot, thermometer or inverse thermometer.
// Latency: zero cycles (pure logic).
// Backpressure: none; err flags out-of-range codes and the reserved mode.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2**IN_W
) (
    input  logic [IN_W-1:0]  code,
    input  mode_e            mode,
    output logic [OUT_W-1:0] word,
    output logic             err
);

    logic [31:0] k;

    always_comb begin
        k    = 32'(code);
        word = '0;
        err  = 1'b0;
        if (k >= 32'(OUT_W)) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                case (mode)
                    MODE_ONEHOT:  word[i] = (unsigned'(i) == k);
                    MODE_THERMO:  word[i] = (unsigned'(i) <= k);
                    MODE_ITHERMO: word[i] = (unsigned'(i) >= k);
                    default:      err     = 1'b1;
                endcase
            end
        end
        // Any error blanks the word so downstream enables never see a partial pattern.
        if (err) begin
            word = '0;
        end
    end

endmodule

// File: rtl/decoder_strobe_gen.sv
// Registered decoder that holds the decoded word as a strobe for in_hold+1 cycles.
// Latency: request accepted at edge N is visible on out right after edge N.
// Backpressure: in_ready low while a strobe still has cycles left; ready again on its last cycle.
module decoder_strobe_gen
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2**IN_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic [1:0]       in_mode,
    input  logic [CNT_W-1:0] in_hold,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             out_err,
    output logic             busy
);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [OUT_W-1:0]   out_nxt;
    logic               out_valid_nxt;
    logic               out_err_nxt;
    logic [OUT_W-1:0]   dec_word;
    logic               dec_err;
    logic               accept;

    decoder_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .code (in_code),
        .mode (mode_e'(in_mode)),
        .word (dec_word),
        .err  (dec_err)
    );

    // Ready on the final hold cycle too, so strobes can run back to back.
    assign in_ready = rst_n && ((state == IDLE) || (cnt == '0));
    assign accept   = in_valid && in_ready;
    assign busy     = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            out_err   <= out_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        out_err_nxt   = out_err;
        if (accept) begin
            state_nxt     = HOLD;
            cnt_nxt       = in_hold;
            out_nxt       = dec_word;
            out_valid_nxt = 1'b1;
            out_err_nxt   = dec_err;
        end else if (state == HOLD) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - 1'b1;
            end else begin
                state_nxt     = IDLE;
                out_nxt       = '0;
                out_valid_nxt = 1'b0;
                out_err_nxt   = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_strobe_gen.sv
// Directed bench for decoder_strobe_gen: vector table plus hand-written multi-cycle sequences.
module tb_decoder_strobe_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_code = '0;
    logic [1:0] in_mode = '0;
    logic [7:0] in_hold = '0;
    logic [7:0] out;
    logic       out_valid, out_err, busy;

    logic       in_valid6 = 1'b0;
    logic       in_ready6;
    logic [2:0] in_code6 = '0;
    logic [1:0] in_mode6 = '0;
    logic [7:0] in_hold6 = '0;
    logic [5:0] out6;
    logic       out_valid6, out_err6, busy6;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decoder_strobe_gen #(.IN_W(3), .OUT_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_mode(in_mode), .in_hold(in_hold),
        .out(out), .out_valid(out_valid), .out_err(out_err), .busy(busy)
    );

    decoder_strobe_gen #(.IN_W(3), .OUT_W(6), .CNT_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_code(in_code6), .in_mode(in_mode6), .in_hold(in_hold6),
        .out(out6), .out_valid(out_valid6), .out_err(out_err6), .busy(busy6)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] code;
        logic [1:0] mode;
        logic [7:0] hold;
        logic [7:0] exp_out;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int cycles;
        int bad_word;

        vecs[0] = '{3'd3, 2'b00, 8'd0, 8'b0000_1000, 1'b0};
        vecs[1] = '{3'd5, 2'b01, 8'd3, 8'b0011_1111, 1'b0};
        vecs[2] = '{3'd6, 2'b10, 8'd1, 8'b1100_0000, 1'b0};
        vecs[3] = '{3'd7, 2'b11, 8'd2, 8'b0000_0000, 1'b1};
        vecs[4] = '{3'd0, 2'b01, 8'd0, 8'b0000_0001, 1'b0};
        vecs[5] = '{3'd0, 2'b10, 8'd0, 8'b1111_1111, 1'b0};
        vecs[6] = '{3'd7, 2'b01, 8'd1, 8'b1111_1111, 1'b0};
        vecs[7] = '{3'd7, 2'b10, 8'd0, 8'b1000_0000, 1'b0};
        vecs[8] = '{3'd7, 2'b00, 8'd0, 8'b1000_0000, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", in_ready, 1);

        // Table: strobe content and exact width
        for (int v = 0; v < 9; v++) begin
            in_code  = vecs[v].code;
            in_mode  = vecs[v].mode;
            in_hold  = vecs[v].hold;
            in_valid = 1'b1;
            for (int k = 0; k <= int'(vecs[v].hold); k++) begin
                @(negedge clk);
                check($sformatf("v%0d_out_c%0d", v, k), out, vecs[v].exp_out);
                check($sformatf("v%0d_err_c%0d", v, k), out_err, vecs[v].exp_err);
                check($sformatf("v%0d_valid_c%0d", v, k), out_valid, 1);
                check($sformatf("v%0d_busy_c%0d", v, k), busy, 1);
                check($sformatf("v%0d_ready_c%0d", v, k), in_ready, (k == int'(vecs[v].hold)) ? 1 : 0);
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("v%0d_idle_out", v), out, 0);
            check($sformatf("v%0d_idle_valid", v), out_valid, 0);
            check($sformatf("v%0d_idle_err", v), out_err, 0);
            check($sformatf("v%0d_idle_busy", v), busy, 0);
            check($sformatf("v%0d_idle_ready", v), in_ready, 1);
        end

        // Back-to-back with in_valid held high; new inputs ignored until ready
        in_code = 3'd6; in_mode = 2'b10; in_hold = 8'd1; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_c0", out, 8'b1100_0000);
        check("b2b_ready_c0", in_ready, 0);
        in_code = 3'd1; in_mode = 2'b00; in_hold = 8'd0;
        @(negedge clk);
        check("b2b_first_c1", out, 8'b1100_0000);
        check("b2b_ready_c1", in_ready, 1);
        @(negedge clk);
        check("b2b_second", out, 8'b0000_0010);
        check("b2b_second_valid", out_valid, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_idle_out", out, 0);
        check("b2b_idle_valid", out_valid, 0);

        // OUT_W=6 instance: out-of-range code and narrow decodes
        in_code6 = 3'd6; in_mode6 = 2'b00; in_hold6 = 8'd0; in_valid6 = 1'b1;
        @(negedge clk);
        check("w6_range_out", out6, 0);
        check("w6_range_err", out_err6, 1);
        check("w6_range_valid", out_valid6, 1);
        in_code6 = 3'd5; in_mode6 = 2'b01;
        @(negedge clk);
        check("w6_thermo_out", out6, 6'b11_1111);
        check("w6_thermo_err", out_err6, 0);
        in_code6 = 3'd5; in_mode6 = 2'b10;
        @(negedge clk);
        check("w6_ithermo_out", out6, 6'b10_0000);
        in_code6 = 3'd7; in_mode6 = 2'b10;
        @(negedge clk);
        check("w6_range7_out", out6, 0);
        check("w6_range7_err", out_err6, 1);
        in_valid6 = 1'b0;
        @(negedge clk);
        check("w6_idle_valid", out_valid6, 0);
        check("w6_idle_err", out_err6, 0);

        // Asynchronous reset in the middle of a long hold
        in_code = 3'd7; in_mode = 2'b00; in_hold = 8'd10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_out", out, 8'b1000_0000);
        repeat (4) @(posedge clk);
        #2;
        check("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_out", out, 0);
        check("post_rst_valid", out_valid, 0);

        // Maximum hold: 256-cycle strobe, no counter wrap
        in_code = 3'd0; in_mode = 2'b00; in_hold = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        bad_word = 0;
        while (out_valid && cycles < 300) begin
            if (out !== 8'b0000_0001) bad_word++;
            cycles++;
            @(negedge clk);
        end
        check("max_hold_cycles", cycles, 256);
        check("max_hold_bad_words", bad_word, 0);
        check("max_hold_idle_out", out, 0);
        check("max_hold_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_strobe_gen.md
Name: decoder_strobe_gen

Overview:
- Parametrised, registered successor to the team's 3-to-8 combinational decoder.
- Accepts a binary code over a valid/ready handshake and decodes it to an OUT_W-bit word in one of three modes: one-hot, thermometer or inverse thermometer.
- Holds the decoded word as a strobe for a programmable number of cycles, then returns the output to idle.
- Sits between control logic and downstream select/enable lines that need stable, glitch-free, timed strobes.

Parameters:
- IN_W, 3, width of the input code.
- OUT_W, 2**IN_W, number of output lines; legal range 2..2**IN_W.
- CNT_W, 8, width of the hold-length field and the internal hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_code  input  IN_W  binary code to decode.
- in_mode  input  2  00 one-hot, 01 thermometer, 10 inverse thermometer, 11 reserved.
- in_hold  input  CNT_W  extra hold cycles; strobe lasts in_hold+1 cycles.
- out  output  OUT_W  registered decoded word.
- out_valid  output  1  out carries a decoded word.
- out_err  output  1  current strobe came from an illegal request.
- busy  output  1  state is HOLD.

Behaviour:
- Single clock domain; reset is asynchronous and active-low, named rst_n, clocked by clk.
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, counter = 0.
  - out = 0, out_valid = 0, out_err = 0, busy = 0.
  - in_ready = 0 while rst_n is low.
- States: IDLE, HOLD.
- in_ready is combinational: 1 when state == IDLE, or when state == HOLD and cnt == 0 (back-to-back acceptance).
- Accept happens when in_valid && in_ready at a rising edge. At that edge:
  - out loads the decoded word; out_valid = 1; out_err loads the error flag.
  - cnt loads in_hold; state goes to HOLD.
  - Latency: request at edge N, output visible after edge N.
- Decode, with k = in_code:
  - One-hot: out[i] = (i == k).
  - Thermometer: out[i] = (i <= k).
  - Inverse thermometer: out[i] = (i >= k).
  - All compares are unsigned, zero-extended to the wider width.
- Error cases force out = 0 and out_err = 1, with the strobe still timed normally (out_valid = 1 for in_hold+1 cycles):
  - k >= OUT_W (possible only when OUT_W < 2**IN_W).
  - in_mode == 11.
- HOLD state:
  - When cnt != 0: cnt decrements by 1 each cycle; out, out_valid and out_err are stable.
  - When cnt == 0 and an accept occurs: new word loaded; stays in HOLD; no idle gap.
  - When cnt == 0 and no accept: state goes to IDLE; out = 0, out_valid = 0, out_err = 0 at that edge.
- Strobe width is exactly in_hold+1 cycles. in_hold = 0 gives a single-cycle pulse. in_hold = 2**CNT_W-1 gives 2**CNT_W cycles, with no wrap on the counter.
- busy = (state == HOLD).
- Inputs are sampled only at accept; changes during HOLD are ignored.
- If rst_n asserts mid-HOLD, outputs clear immediately and the pending strobe is discarded.
- in_valid without in_ready: the request is simply not taken. There is no buffering and no error.

Decomposition:
- Package decoder_pkg holds:
  - mode_e enum: MODE_ONEHOT = 2'b00, MODE_THERMO = 2'b01, MODE_ITHERMO = 2'b10, MODE_RSVD = 2'b11.
  - state_e enum: IDLE, HOLD.
- Sub-module decoder_core: purely combinational, parametrised on IN_W and OUT_W.
  - Inputs: code, mode. Outputs: word, err.
  - Instantiated once; the top module holds the FSM, counter and output registers.

Test Plan:
1. Reset, then one-hot: code=3'b011, mode=00, hold=0 -> next edge out=8'b0000_1000, out_valid=1 for 1 cycle, then out=0; in_ready=1 throughout.
2. Thermometer: code=3'b101, mode=01, hold=3 -> out=8'b0011_1111 for exactly 4 cycles; busy=1 and in_ready=0 for the first 3 of those cycles.
3. Back-to-back with in_valid held high: inverse thermometer code=3'b110, mode=10, hold=1, then one-hot code=3'b001, hold=0 -> out=8'b1100_0000 for 2 cycles, immediately followed by 8'b0000_0010 for 1 cycle, with no zero gap.
4. Errors: mode=11, code=3'b111, hold=2 -> out=0, out_err=1, out_valid=1 for 3 cycles. Rebuild with OUT_W=6: code=3'b110, mode=00 -> out=6'b0, out_err=1.
5. Reset mid-hold: accept code=3'b111, mode=00, hold=10, then pull rst_n low 4 cycles later, asynchronously -> out, out_valid and busy drop without waiting for clk; after release, in_ready=1 and out=0.
6. Max hold: hold=8'hFF, code=3'b000, mode=00 -> out=8'b0000_0001 for exactly 256 cycles, then idle.
